// File: rtl/stoch_nmax_window_ctrl.sv
// stoch_nmax_window_ctrl: clears, warms up and integrates one window of a signed stochastic max tree, then hands the estimate off.
module stoch_nmax_window_ctrl #(
    parameter int CLEAR_LEN  = 2,
    parameter int WARMUP_LEN = 16,
    parameter int WINDOW_LEN = 256,
    parameter int ACC_WIDTH  = $clog2(WINDOW_LEN) + 2
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        y_p,
    input  logic                        y_m,
    output logic                        tree_clr,
    output logic                        tree_en,
    output logic                        busy,
    output logic signed [ACC_WIDTH-1:0] result,
    output logic                        result_valid,
    input  logic                        result_ready
);
    localparam int MAX_LEN = (CLEAR_LEN > WARMUP_LEN)
        ? ((CLEAR_LEN > WINDOW_LEN) ? CLEAR_LEN : WINDOW_LEN)
        : ((WARMUP_LEN > WINDOW_LEN) ? WARMUP_LEN : WINDOW_LEN);
    localparam int CW = $clog2(MAX_LEN) + 1;
    localparam logic [CW-1:0] CLR_LD = CW'(CLEAR_LEN - 1);
    localparam logic [CW-1:0] WU_LD  = CW'((WARMUP_LEN > 0) ? WARMUP_LEN - 1 : 0);
    localparam logic [CW-1:0] WIN_LD = CW'(WINDOW_LEN - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, WARMUP, ACCUM, DONE} state_t;

    state_t                        state, state_nx;
    logic [CW-1:0]                 cnt, cnt_nx;
    logic signed [ACC_WIDTH-1:0]   acc, acc_nx, step;

    // per-cycle contribution of the tree output: +1, -1 or 0
    always_comb step = (y_p & ~y_m) ? ACC_WIDTH'(1) : (y_m & ~y_p) ? {ACC_WIDTH{1'b1}} : '0;

    // next-state, phase counter and accumulator; the counter counts down to zero in every phase
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        acc_nx   = acc;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state_nx = CLEAR;
                    cnt_nx   = CLR_LD;
                    acc_nx   = '0;
                end
                CLEAR: if (cnt == '0) begin
                    state_nx = (WARMUP_LEN > 0) ? WARMUP : ACCUM;
                    cnt_nx   = (WARMUP_LEN > 0) ? WU_LD : WIN_LD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
                WARMUP: if (cnt == '0) begin
                    state_nx = ACCUM;
                    cnt_nx   = WIN_LD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
                ACCUM: begin
                    acc_nx   = acc + step;
                    state_nx = (cnt == '0) ? DONE : ACCUM;
                    cnt_nx   = (cnt == '0) ? cnt : cnt - 1'b1;
                end
                DONE: if (result_ready) begin
                    state_nx = start ? CLEAR : IDLE;
                    cnt_nx   = start ? CLR_LD : cnt;
                    acc_nx   = start ? '0 : acc;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // state registers with outputs decoded from the next state so they are glitch-free registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= '0;
            tree_clr     <= 1'b0;
            tree_en      <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            acc          <= acc_nx;
            tree_clr     <= state_nx == CLEAR;
            tree_en      <= state_nx == WARMUP || state_nx == ACCUM;
            busy         <= state_nx != IDLE;
            result_valid <= state_nx == DONE;
            if (state == ACCUM && state_nx == DONE)
                result <= acc_nx;
        end
    end
endmodule
